// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversamples the SPI pins in the clk domain, deserialises MOSI
// into bytes (MSB first) and returns bytes on MISO from a one-deep holding register.
module spi_slave_rx #(
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_ready_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_hist_q;
    logic                   cs_hist_q;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
    logic [7:0] tx_shift_q;
    logic [7:0] tx_hold_q;
    logic       hold_valid_q;
    logic       first_shift_q;
    logic       reload_q;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       nclk;
    logic       sclk_edge;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;
    logic       shift_edge;
    logic       cs_fall;
    logic       cs_rise;
    logic [7:0] rx_byte_d;
    logic [7:0] tx_next_d;
    logic       tx_consume;

    // MOSI shares the SCLK synchroniser depth so a sampled bit lines up with its edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= CPOL;
            cs_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign nclk        = sclk_s ^ CPOL;
    assign sclk_edge   = sclk_s != sclk_hist_q;
    assign lead_edge   = sclk_edge & nclk;
    assign trail_edge  = sclk_edge & ~nclk;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_hist_q & ~cs_s;
    assign cs_rise     = ~cs_hist_q & cs_s;

    assign rx_byte_d  = {rx_shift_q[6:0], mosi_s};
    assign tx_next_d  = hold_valid_q ? tx_hold_q : 8'hFF;
    assign tx_consume = ((state_q == IDLE) & cs_fall)
                      | ((state_q == ACTIVE) & ~cs_rise & shift_edge & reload_q);

    // A consume of a full holding register takes priority over a new load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_shift_q    <= 8'hFF;
            tx_hold_q     <= 8'h00;
            hold_valid_q  <= 1'b0;
            first_shift_q <= 1'b0;
            reload_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q       <= ACTIVE;
                        bit_cnt_q     <= 3'd0;
                        tx_shift_q    <= tx_next_d;
                        first_shift_q <= 1'b1;
                        reload_q      <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        frame_err_q <= bit_cnt_q != 3'd0;
                        bit_cnt_q   <= 3'd0;
                        reload_q    <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_byte_d;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= rx_byte_d;
                                rx_valid_q <= 1'b1;
                                bit_cnt_q  <= 3'd0;
                                reload_q   <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                        // Under CPHA=1 the first shift edge of a byte presents the MSB instead of shifting.
                        if (shift_edge) begin
                            first_shift_q <= 1'b0;
                            if (reload_q) begin
                                tx_shift_q <= tx_next_d;
                                reload_q   <= 1'b0;
                            end else if (!(CPHA && first_shift_q)) begin
                                tx_shift_q <= {tx_shift_q[6:0], 1'b1};
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (tx_consume && hold_valid_q) begin
                hold_valid_q <= 1'b0;
            end else if (tx_load_i && !hold_valid_q) begin
                tx_hold_q    <= tx_data_i;
                hold_valid_q <= 1'b1;
            end
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign frame_err_o   = frame_err_q;
    assign tx_ready_o    = ~hold_valid_q;
    assign busy_o        = state_q == ACTIVE;
    assign spi_miso_oe_o = state_q == ACTIVE;
    assign spi_miso_o    = (state_q == ACTIVE) & tx_shift_q[7];

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: three instances (CPOL/CPHA 00, 11, 01) driven
// by a bit-level SPI master, with a timed queue model for rx_valid/frame_err strobes.
module tb_spi_slave_rx;

    localparam int       SYNC  = 2;
    localparam int       HALF  = 50;
    localparam bit [2:0] CPOLV = 3'b010;
    localparam bit [2:0] CPHAV = 3'b110;

    typedef struct {
        int         cfg;
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sclk;
    logic [2:0] csn;
    logic [2:0] mosi;
    logic [2:0] miso;
    logic [2:0] misoOe;
    logic [7:0] rxData [3];
    logic [2:0] rxValid;
    logic [7:0] txData [3];
    logic [2:0] txLoad;
    logic [2:0] txReady;
    logic [2:0] frameErr;
    logic [2:0] busy;

    int         cycCount = 0;
    int         checks   = 0;
    int         passes   = 0;
    exp_t       expRx[$];
    exp_t       expErr[$];
    logic [7:0] txBytes [4];
    logic [7:0] misoBytes [4];

    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    spi_slave_rx #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SYNC)) u00 (
        .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk[0]), .spi_cs_n_i(csn[0]),
        .spi_mosi_i(mosi[0]), .spi_miso_o(miso[0]), .spi_miso_oe_o(misoOe[0]),
        .rx_data_o(rxData[0]), .rx_valid_o(rxValid[0]), .tx_data_i(txData[0]),
        .tx_load_i(txLoad[0]), .tx_ready_o(txReady[0]), .frame_err_o(frameErr[0]),
        .busy_o(busy[0]));

    spi_slave_rx #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(SYNC)) u11 (
        .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk[1]), .spi_cs_n_i(csn[1]),
        .spi_mosi_i(mosi[1]), .spi_miso_o(miso[1]), .spi_miso_oe_o(misoOe[1]),
        .rx_data_o(rxData[1]), .rx_valid_o(rxValid[1]), .tx_data_i(txData[1]),
        .tx_load_i(txLoad[1]), .tx_ready_o(txReady[1]), .frame_err_o(frameErr[1]),
        .busy_o(busy[1]));

    spi_slave_rx #(.CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(SYNC)) u01 (
        .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk[2]), .spi_cs_n_i(csn[2]),
        .spi_mosi_i(mosi[2]), .spi_miso_o(miso[2]), .spi_miso_oe_o(misoOe[2]),
        .rx_data_o(rxData[2]), .rx_valid_o(rxValid[2]), .tx_data_i(txData[2]),
        .tx_load_i(txLoad[2]), .tx_ready_o(txReady[2]), .frame_err_o(frameErr[2]),
        .busy_o(busy[2]));

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after a posedge, so a strobe caused by that change
    // appears after the (SYNC+1)th following posedge.
    task automatic applyStimulus(input int c, input int nBits, input bit raiseCs);
        int byteIdx;
        int bitIdx;
        tick(1);
        csn[c] = 1'b0;
        if (!CPHAV[c]) mosi[c] = txBytes[0][7];
        tick(HALF);
        checkOutput($sformatf("busy[%0d]", c), 32'(busy[c]), 32'd1);
        checkOutput($sformatf("misoOe[%0d]", c), 32'(misoOe[c]), 32'd1);
        for (int k = 0; k < nBits; k++) begin
            byteIdx = k / 8;
            bitIdx  = 7 - (k % 8);
            if (!CPHAV[c]) begin
                sclk[c] = ~CPOLV[c];
                misoBytes[byteIdx][bitIdx] = miso[c];
                if (k % 8 == 7) expRx.push_back('{c, cycCount + SYNC + 1, txBytes[byteIdx]});
                tick(HALF);
                sclk[c] = CPOLV[c];
                if (k + 1 < nBits) mosi[c] = txBytes[(k + 1) / 8][7 - ((k + 1) % 8)];
                tick(HALF);
            end else begin
                sclk[c] = ~CPOLV[c];
                mosi[c] = txBytes[byteIdx][bitIdx];
                tick(HALF);
                sclk[c] = CPOLV[c];
                misoBytes[byteIdx][bitIdx] = miso[c];
                if (k % 8 == 7) expRx.push_back('{c, cycCount + SYNC + 1, txBytes[byteIdx]});
                tick(HALF);
            end
        end
        if (raiseCs) begin
            csn[c] = 1'b1;
            if (nBits % 8 != 0) expErr.push_back('{c, cycCount + SYNC + 1, 8'h00});
            tick(HALF);
            checkOutput($sformatf("busyEnd[%0d]", c), 32'(busy[c]), 32'd0);
        end
    endtask

    task automatic loadTx(input int c, input logic [7:0] d);
        txData[c] = d;
        txLoad[c] = 1'b1;
        tick(1);
        txLoad[c] = 1'b0;
    endtask

    // Every cycle, each strobe must be high exactly when the model scheduled it.
    always @(negedge clk) begin
        bit         got;
        bit         gotErr;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            got    = 1'b0;
            gotErr = 1'b0;
            d      = 8'h00;
            for (int k = expRx.size() - 1; k >= 0; k--) begin
                if (expRx[k].cfg == i && expRx[k].cyc == cycCount) begin
                    got = 1'b1;
                    d   = expRx[k].data;
                    expRx.delete(k);
                end
            end
            for (int k = expErr.size() - 1; k >= 0; k--) begin
                if (expErr[k].cfg == i && expErr[k].cyc == cycCount) begin
                    gotErr = 1'b1;
                    expErr.delete(k);
                end
            end
            checkOutput($sformatf("rxValid[%0d]@%0d", i, cycCount), 32'(rxValid[i]), 32'(got));
            if (got) checkOutput($sformatf("rxData[%0d]@%0d", i, cycCount), 32'(rxData[i]), 32'(d));
            checkOutput($sformatf("frameErr[%0d]@%0d", i, cycCount), 32'(frameErr[i]), 32'(gotErr));
        end
    end

    task automatic checkResetOutputs(input int c);
        checkOutput($sformatf("rstRxData[%0d]", c), 32'(rxData[c]), 32'h00);
        checkOutput($sformatf("rstTxReady[%0d]", c), 32'(txReady[c]), 32'd1);
        checkOutput($sformatf("rstBusy[%0d]", c), 32'(busy[c]), 32'd0);
        checkOutput($sformatf("rstMisoOe[%0d]", c), 32'(misoOe[c]), 32'd0);
        checkOutput($sformatf("rstMiso[%0d]", c), 32'(miso[c]), 32'd0);
        checkOutput($sformatf("rstRxValid[%0d]", c), 32'(rxValid[c]), 32'd0);
        checkOutput($sformatf("rstFrameErr[%0d]", c), 32'(frameErr[c]), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        csn    = 3'b111;
        sclk   = CPOLV;
        mosi   = 3'b000;
        txLoad = 3'b000;
        for (int i = 0; i < 3; i++) txData[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            txBytes[i]   = 8'h00;
            misoBytes[i] = 8'h00;
        end
        tick(5);
        for (int c = 0; c < 3; c++) checkResetOutputs(c);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] single byte 0xA5, mode 0");
        txBytes[0] = 8'hA5;
        applyStimulus(0, 8, 1'b1);
        checkOutput("a5RxData", 32'(rxData[0]), 32'hA5);
        checkOutput("a5MisoIdleFill", 32'(misoBytes[0]), 32'hFF);

        $display("[TB] back-to-back 0x3C 0xC3");
        txBytes[0] = 8'h3C;
        txBytes[1] = 8'hC3;
        applyStimulus(0, 16, 1'b1);
        checkOutput("b2bRxData", 32'(rxData[0]), 32'hC3);

        $display("[TB] partial frame then 0x5A");
        txBytes[0] = 8'hE7;
        applyStimulus(0, 5, 1'b1);
        checkOutput("partialKeepsRxData", 32'(rxData[0]), 32'hC3);
        txBytes[0] = 8'h5A;
        applyStimulus(0, 8, 1'b1);
        checkOutput("afterPartialRxData", 32'(rxData[0]), 32'h5A);

        for (int c = 0; c < 3; c++) begin
            $display("[TB] tx exchange on instance %0d", c);
            loadTx(c, 8'h96);
            checkOutput($sformatf("loadReady[%0d]", c), 32'(txReady[c]), 32'd0);
            loadTx(c, 8'h11);
            checkOutput($sformatf("ignoredLoadReady[%0d]", c), 32'(txReady[c]), 32'd0);
            txBytes[0] = 8'hA5;
            txBytes[1] = 8'h5A;
            applyStimulus(c, 16, 1'b1);
            checkOutput($sformatf("misoByte0[%0d]", c), 32'(misoBytes[0]), 32'h96);
            checkOutput($sformatf("misoByte1[%0d]", c), 32'(misoBytes[1]), 32'hFF);
            checkOutput($sformatf("exchRxData[%0d]", c), 32'(rxData[c]), 32'h5A);
            checkOutput($sformatf("exchReady[%0d]", c), 32'(txReady[c]), 32'd1);
        end

        $display("[TB] reset mid-frame");
        txBytes[0] = 8'hF0;
        applyStimulus(0, 4, 1'b0);
        rst_n  = 1'b0;
        csn[0] = 1'b1;
        tick(2);
        checkResetOutputs(0);
        rst_n = 1'b1;
        tick(5);
        checkResetOutputs(0);
        txBytes[0] = 8'h0F;
        applyStimulus(0, 8, 1'b1);
        checkOutput("postResetRxData", 32'(rxData[0]), 32'h0F);

        tick(10);
        checkOutput("pendingRxStrobes", 32'(expRx.size()), 32'd0);
        checkOutput("pendingErrStrobes", 32'(expErr.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
